// File: rtl/wrr_arbiter_apb.sv
// Weighted round-robin arbiter with an APB register file: 1-cycle request-to-grant latency.
// No backpressure: APB is zero-wait-state; grants are registered and re-evaluated every cycle.
module wrr_arbiter_apb #(
  parameter int NUM_REQ  = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                Pclk_i,
  input  logic                PResetn_i,
  input  logic                PSel_i,
  input  logic                PEnable_i,
  input  logic                PWrite_i,
  input  logic [7:0]          PAddr_i,
  input  logic [31:0]         PWData_i,
  output logic [31:0]         PRData_o,
  output logic                PReady_o,
  output logic                PSlvErr_o,
  input  logic [NUM_REQ-1:0]  req_i,
  output logic [NUM_REQ-1:0]  gnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [WEIGHT_W:0]   ONE_WX = 1;
  localparam logic [WEIGHT_W-1:0] ONE_W  = 1;
  localparam logic [IDX_W-1:0]    ONE_I  = 1;
  localparam logic [IDX_W-1:0]    LAST_I = IDX_W'(NUM_REQ - 1);

  typedef struct packed {
    logic mode;
    logic en;
  } ctrl_t;

  ctrl_t               ctrl_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_REQ];
  logic [31:0]         gnt_cnt_q;
  logic [IDX_W-1:0]    idx_q, ptr_q;
  logic                vld_q;
  logic [WEIGHT_W-1:0] cred_q;
  logic [NUM_REQ-1:0]  gnt_q;

  logic acc, wr_acc, rd_acc;
  logic sel_ctrl, sel_stat, sel_cnt, w_hit, mapped;
  logic [5:0] w_sel;
  logic unused_wdata;

  assign acc      = PSel_i & PEnable_i;
  assign wr_acc   = acc & PWrite_i;
  assign rd_acc   = acc & ~PWrite_i;
  assign sel_ctrl = (PAddr_i == 8'h00);
  assign sel_stat = (PAddr_i == 8'h04);
  assign sel_cnt  = (PAddr_i == 8'h08);
  assign w_sel    = PAddr_i[7:2] - 6'h04;
  assign w_hit    = (PAddr_i >= 8'h10) && (PAddr_i[1:0] == 2'b00) && (int'(w_sel) < NUM_REQ);
  assign mapped   = sel_ctrl | sel_stat | sel_cnt | w_hit;
  assign unused_wdata = ^PWData_i;

  logic [5:0]  req_cnt;
  logic [31:0] status, rdata;

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) req_cnt = req_cnt + 6'(req_i[i]);
    status = '0;
    status[IDX_W-1:0] = idx_q;
    status[8]         = vld_q;
    status[21:16]     = req_cnt;
  end

  always_comb begin
    rdata = '0;
    if (sel_ctrl) rdata[1:0] = ctrl_q;
    if (sel_stat) rdata      = status;
    if (sel_cnt)  rdata      = gnt_cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_hit && w_sel == 6'(i)) rdata[WEIGHT_W-1:0] = weight_q[i];
  end

  // Reset gates the combinational read path so the bus stays quiet while held.
  assign PRData_o  = (rd_acc && PResetn_i) ? rdata : '0;
  assign PSlvErr_o = acc & ~mapped & PResetn_i;
  assign PReady_o  = 1'b1;
  assign gnt_o     = gnt_q;

  logic                cur_req, hold, found;
  logic [WEIGHT_W-1:0] cur_w, eff_w;
  logic [IDX_W-1:0]    start, start_nx, off, nxt;
  logic [NUM_REQ-1:0]  req_rot;
  int                  sum_i;

  always_comb begin
    cur_req = 1'b0;
    cur_w   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (idx_q == IDX_W'(i)) begin
        cur_req = req_i[i];
        cur_w   = weight_q[i];
      end
    eff_w = (!ctrl_q.mode || cur_w == '0) ? ONE_W : cur_w;
    hold  = vld_q && cur_req && (({1'b0, cred_q} + ONE_WX) < {1'b0, eff_w});

    // Rotate so bit 0 is the index after start; start itself lands in the top bit, checked last.
    start    = vld_q ? idx_q : ptr_q;
    start_nx = (start == LAST_I) ? '0 : start + ONE_I;
    req_rot  = NUM_REQ'({req_i, req_i} >> start_nx);
    found    = 1'b0;
    off      = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    sum_i = int'(start_nx) + int'(off);
    nxt   = IDX_W'((sum_i >= NUM_REQ) ? sum_i - NUM_REQ : sum_i);
  end

  always_ff @(posedge Pclk_i or negedge PResetn_i) begin
    if (!PResetn_i) begin
      ctrl_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) weight_q[i] <= ONE_W;
      gnt_cnt_q <= '0;
      idx_q     <= '0;
      ptr_q     <= LAST_I;
      vld_q     <= 1'b0;
      cred_q    <= '0;
      gnt_q     <= '0;
    end else begin
      if (wr_acc && sel_ctrl) ctrl_q <= ctrl_t'(PWData_i[1:0]);
      for (int i = 0; i < NUM_REQ; i++)
        if (wr_acc && w_hit && w_sel == 6'(i)) weight_q[i] <= PWData_i[WEIGHT_W-1:0];

      if (!ctrl_q.en) begin
        vld_q <= 1'b0;
        gnt_q <= '0;
      end else if (hold) begin
        cred_q <= cred_q + ONE_W;
      end else if (found) begin
        idx_q  <= nxt;
        ptr_q  <= nxt;
        vld_q  <= 1'b1;
        cred_q <= '0;
        gnt_q  <= NUM_REQ'(1) << nxt;
      end else begin
        vld_q <= 1'b0;
        gnt_q <= '0;
      end

      // A software clear wins over a same-edge increment.
      if (wr_acc && sel_cnt)
        gnt_cnt_q <= '0;
      else if (ctrl_q.en && !hold && found)
        gnt_cnt_q <= gnt_cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/wrr_arbiter_apb.md
WRR_ARBITER_APB -- requirements
Module: wrr_arbiter_apb

Interface
REQ-001 Parameter NUM_REQ, default 8, meaning number of requesters; legal 2..32.
REQ-002 Parameter WEIGHT_W, default 4, meaning width of each per-requester weight field; legal 1..8.
REQ-003 Pclk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 PResetn_i  input  1  reset, asynchronous, active-low.
REQ-005 PSel_i  input  1  APB select.
REQ-006 PEnable_i  input  1  APB access phase.
REQ-007 PWrite_i  input  1  1 = write, 0 = read.
REQ-008 PAddr_i  input  8  byte address.
REQ-009 PWData_i  input  32  write data.
REQ-010 PRData_o  output  32  read data.
REQ-011 PReady_o  output  1  APB ready; tied to 1 (zero wait states).
REQ-012 PSlvErr_o  output  1  APB error.
REQ-013 req_i  input  NUM_REQ  request per client, level-sensitive.
REQ-014 gnt_o  output  NUM_REQ  registered one-hot grant, or all-zero.

Function
REQ-015 An APB access is PSel_i & PEnable_i; writes take effect on that edge; reads are not registered.
REQ-016 PRData_o SHALL equal the addressed register during a read access and 0 at all other times.
REQ-017 PSlvErr_o SHALL be 1 during an access to an unmapped address; writes to unmapped addresses are ignored.
REQ-018 Register 0x00 CTRL (RW): bit0 enable, bit1 mode (0 = plain round-robin, 1 = weighted); other bits read 0.
REQ-019 Register 0x04 STATUS (RO): [4:0] current grant index, [8] grant valid, [21:16] popcount of req_i; writes ignored, no error.
REQ-020 Register 0x08 GNT_CNT (RW): 32-bit count of new grant issues, wraps at 2^32; any write clears it to 0.
REQ-021 Registers 0x10+4*i, i < NUM_REQ, WEIGHT[i] (RW): [WEIGHT_W-1:0] = maximum consecutive grant cycles for requester i; upper bits read 0.
REQ-022 Effective weight = 1 when mode = 0 or WEIGHT[i] = 0; otherwise it is WEIGHT[i].
REQ-023 State: grant index idx, grant valid vld, credit counter cred (width WEIGHT_W), and last-served pointer ptr.
REQ-024 Hold: if vld, req_i[idx] = 1 and cred+1 < effective weight of idx, the grant holds and cred increments.
REQ-025 Rotate: otherwise search req_i from (vld ? idx : ptr)+1, wrapping modulo NUM_REQ, with the start index itself checked last; the first set bit becomes idx, with vld=1, cred=0, ptr=idx and GNT_CNT incremented.
REQ-026 A rotate that selects the same index as the current grant (sole requester) counts as a new grant issue.
REQ-027 If the search finds no request, vld goes to 0 while ptr and idx hold.
REQ-028 gnt_o SHALL be onehot(idx) when vld=1, else 0; the latency from a request on an idle arbiter to its grant is 1 cycle.
REQ-029 When a granted request drops, gnt_o SHALL change on the next edge; no cycle is lost between back-to-back grants.
REQ-030 Enable = 0: vld is forced to 0 on the next edge; arbitration is frozen; ptr is kept; GNT_CNT does not count.
REQ-031 Re-enabling resumes the search from ptr+1.
REQ-032 A WEIGHT or mode write during an active grant takes effect on the following cycle's hold comparison; cred is not reset.
REQ-033 A CTRL write and an arbitration decision on the same edge: the decision uses the old CTRL value.
REQ-034 A GNT_CNT clear and a grant increment on the same edge: the result is 0.

Reset
REQ-035 While PResetn_i = 0: CTRL=0, all WEIGHT=1, GNT_CNT=0, vld=0, idx=0, cred=0, ptr=NUM_REQ-1, gnt_o=0.
REQ-036 While PResetn_i = 0, PRData_o=0 and PSlvErr_o=0.
REQ-037 Reset asserted mid-grant SHALL clear gnt_o immediately (asynchronously).
REQ-038 After reset release, the first grant goes to the lowest-index requester.

Verification
REQ-039 Write CTRL=0x1, req_i=0x05 held -> gnt_o sequence 0x01,0x04,0x01,0x04; GNT_CNT increments every cycle.
REQ-040 Write CTRL=0x3, WEIGHT[0]=3, WEIGHT[2]=1, req_i=0x05 held -> gnt_o sequence 0x01 x3, 0x04 x1, repeating.
REQ-041 Grant on req 1; drop req_i[1] while req_i[3]=1 -> gnt_o=0x08 on the next edge, no idle cycle.
REQ-042 Clear CTRL.enable mid-grant -> gnt_o=0 on the next edge and STATUS[8]=0; re-enable -> search resumes after ptr.
REQ-043 Read 0xFC -> PSlvErr_o=1, PRData_o=0; read STATUS with req_i=0x0F -> [21:16]=4.
REQ-044 Assert PResetn_i=0 asynchronously during a grant -> gnt_o=0 before the next edge; all registers return to their reset values.
